// File: rtl/serial_word_transmitter.sv
// Parallel-in, serial-out word transmitter.
// A valid/ready handshake fills a one-word holding register. A shift
// register then sends the word one bit per clock on q, with frame high
// for every bit of the word and last high on its final bit. When a word
// is waiting, it follows the previous word with no idle bit in between.
module serial_word_transmitter #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] Data,
    input  logic         Valid,
    output logic         Ready,
    output logic         Q,
    output logic         Frame,
    output logic         Last
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic            hold_valid;
    logic [N-1:0]    hold;
    logic [N-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            load;

    // Handshake and load decisions. Ready also drops while Reset is held.
    // An accept needs an empty holder and a load needs a full one, so the
    // two never happen on the same edge.
    always_comb begin
        Ready  = !hold_valid && !Reset;
        accept = Valid && Ready;
        load   = ((state == IDLE) || Last) && hold_valid;
    end

    // Serial outputs, decoded only from registered state so that an
    // asynchronous reset clears them without waiting for a clock.
    always_comb begin
        Frame = (state == SHIFT);
        Last  = Frame && (cnt == CNT_LAST);
        if (state == SHIFT) begin
            Q = MSB_FIRST ? shreg[N-1] : shreg[0];
        end else begin
            Q = 1'b0;
        end
    end

    // Holding register, shift register, bit counter and the two-state FSM.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold       <= '0;
            shreg      <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                hold       <= Data;
                hold_valid <= 1'b1;
            end
            if (load) begin
                // Start a new word. This also happens on the final bit of
                // the previous word, so consecutive words run back to back.
                shreg      <= hold;
                cnt        <= '0;
                hold_valid <= 1'b0;
                state      <= SHIFT;
            end else if (state == SHIFT) begin
                if (MSB_FIRST) begin
                    shreg <= {shreg[N-2:0], 1'b0};
                end else begin
                    shreg <= {1'b0, shreg[N-1:1]};
                end
                if (Last) begin
                    // Final bit sent and nothing waiting: go idle.
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Testbench for serial_word_transmitter. Two instances share the inputs,
// one sending MSB first and one sending LSB first. A queue-based model
// predicts both bit streams, and each scenario task checks every cycle.
module tb_serial_word_transmitter;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Valid;
    logic [7:0] Data;
    logic       Ready, Q, Frame, Last;
    logic       ready_l, q_l, frame_l, last_l;

    always #5 Clock = ~Clock;

    serial_word_transmitter #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .Clock(Clock), .Reset(Reset), .Data(Data), .Valid(Valid),
        .Ready(Ready), .Q(Q), .Frame(Frame), .Last(Last)
    );

    serial_word_transmitter #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .Clock(Clock), .Reset(Reset), .Data(Data), .Valid(Valid),
        .Ready(ready_l), .Q(q_l), .Frame(frame_l), .Last(last_l)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the bits still to be sent for the word on the line
    // (MSB-first and LSB-first orders), plus the one pending word.
    bit         mq[$];
    bit         lq[$];
    logic [7:0] pend;
    bit         pend_v  = 1'b0;
    int         accepts = 0;

    function automatic logic [7:0] expected();
        logic r, f, l, qm, ql;
        r  = !pend_v && !Reset;
        f  = (mq.size() > 0);
        l  = (mq.size() == 1);
        qm = f ? mq[0] : 1'b0;
        ql = f ? lq[0] : 1'b0;
        return {r, f, l, qm, r, ql, f, l};
    endfunction

    task automatic model_reset();
        mq.delete();
        lq.delete();
        pend_v = 1'b0;
    endtask

    // Model behaviour on one rising edge, using the inputs present at the edge.
    task automatic model_edge();
        bit acc;
        logic [7:0] w;
        if (Reset) begin
            model_reset();
            return;
        end
        acc = Valid && !pend_v;
        if (mq.size() > 0) begin
            void'(mq.pop_front());
            void'(lq.pop_front());
        end
        if (pend_v && mq.size() == 0) begin
            w = pend;
            for (int i = 0; i < 8; i++) begin
                mq.push_back(w[7-i]);
                lq.push_back(w[i]);
            end
            pend_v = 1'b0;
        end
        if (acc) begin
            pend    = Data;
            pend_v  = 1'b1;
            accepts = accepts + 1;
            $display("accept word=%02h (accept #%0d) at %0t", Data, accepts, $time);
        end
    endtask

    // One clock: step the model at the edge, return 1 time unit later.
    task automatic advance();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs, exp;
        Reset = 1'b1; Valid = 1'b1; Data = 8'hFF;
        model_reset();
        advance();
        advance();
        @(negedge Clock);
        obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = 8'h00;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, exp); end
        Valid = 1'b0;
        advance();
        Reset = 1'b0;
        @(negedge Clock);
        obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = 8'b1000_1000;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, exp); end
        advance();
    endtask

    task automatic test_single();
        logic [7:0] obs, exp, got, got_l;
        int bits, lasts, base;
        bits = 0; lasts = 0; got = '0; got_l = '0; base = accepts;
        for (int c = 0; c < 14; c++) begin
            Valid = (accepts == base);
            Data  = 8'hA5;
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL single cyc=%0d got=%b exp=%b", c, obs, exp); end
            if (Frame) begin
                got = {got[6:0], Q};
                got_l[bits%8] = q_l;
                bits++;
                if (Last) lasts++;
                if (Last && bits != 8) begin bad++; $display("FAIL single_last_pos got=%0d exp=8", bits); end
            end
            advance();
        end
        total++;
        if (got !== 8'hA5 || bits != 8 || lasts != 1) begin
            bad++; $display("FAIL single_word got=%02h bits=%0d lasts=%0d exp=a5/8/1", got, bits, lasts);
        end
        total++;
        if (got_l !== 8'hA5) begin bad++; $display("FAIL single_lsb got=%02h exp=a5", got_l); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  obs, exp;
        logic [15:0] seq;
        int run, max_run, lasts, n, base;
        run = 0; max_run = 0; lasts = 0; seq = '0; base = accepts;
        for (int c = 0; c < 26; c++) begin
            n = accepts - base;
            Valid = (n < 2);
            Data  = (n == 0) ? 8'hA5 : 8'h3C;
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs, exp); end
            if (Frame) begin
                run++;
                seq = {seq[14:0], Q};
                if (Last) lasts++;
                if (Last && (run % 8) != 0) begin bad++; $display("FAIL b2b_last_pos got=%0d exp=multiple of 8", run); end
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            advance();
        end
        total++;
        if (max_run != 16 || lasts != 2 || seq !== 16'hA53C) begin
            bad++; $display("FAIL b2b_stream got run=%0d lasts=%0d seq=%04h exp 16/2/a53c", max_run, lasts, seq);
        end
    endtask

    task automatic test_stall();
        logic [7:0] obs, exp;
        logic [7:0] words[2];
        int n, base, stalls;
        words[0] = 8'($urandom); words[1] = 8'($urandom);
        base = accepts; stalls = 0;
        for (int c = 0; c < 50; c++) begin
            n = accepts - base;
            Valid = (n < 3);
            Data  = (n < 2) ? words[n] : 8'($urandom);
            @(negedge Clock);
            if (Valid && !Ready) stalls++;
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL stall cyc=%0d got=%b exp=%b", c, obs, exp); end
            advance();
        end
        total++;
        if (stalls == 0 || accepts - base != 3) begin
            bad++; $display("FAIL stall_seen got stalls=%0d accepts=%0d exp >0/3", stalls, accepts - base);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] obs, exp, got_l;
        int bits, base;
        bits = 0; got_l = '0; base = accepts;
        for (int c = 0; c < 12; c++) begin
            Valid = (accepts == base);
            Data  = 8'h01;
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL lsb cyc=%0d got=%b exp=%b", c, obs, exp); end
            if (frame_l) begin
                got_l = {got_l[6:0], q_l};
                bits++;
            end
            advance();
        end
        total++;
        if (got_l !== 8'b1000_0000 || bits != 8) begin
            bad++; $display("FAIL lsb_seq got=%b bits=%0d exp=10000000/8", got_l, bits);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] obs, exp;
        int n, base;
        bit reached;
        base = accepts; reached = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n = accepts - base;
            Valid = (n < 2);
            Data  = (n == 0) ? 8'hFF : 8'h55;
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", c, obs, exp); end
            advance();
            if (mq.size() == 5 && pend_v) begin
                reached = 1'b1;
                break;
            end
        end
        total++;
        if (!reached) begin bad++; $display("FAIL midrst_setup got=not reached exp=3 bits sent with word pending"); end
        Valid = 1'b0;
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = 8'h00;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_async got=%b exp=%b", obs, exp); end
        advance();
        Reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = 8'b1000_1000;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL midrst_after cyc=%0d got=%b exp=%b", c, obs, exp); end
            advance();
        end
    endtask

    task automatic test_valid_pulse_busy();
        logic [7:0] obs, exp;
        int n, base;
        bit pulsed;
        base = accepts; pulsed = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n = accepts - base;
            if (n < 2) begin
                Valid = 1'b1; Data = 8'hC3 ^ 8'(n);
            end else if (!pulsed && pend_v) begin
                Valid = 1'b1; Data = 8'($urandom); pulsed = 1'b1;
            end else begin
                Valid = 1'b0;
            end
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL pulse cyc=%0d got=%b exp=%b", c, obs, exp); end
            advance();
        end
        total++;
        if (!pulsed || accepts - base != 2) begin
            bad++; $display("FAIL pulse_ignored got pulsed=%0d accepts=%0d exp 1/2", pulsed, accepts - base);
        end
    endtask

    task automatic test_random();
        logic [7:0] obs, exp;
        int prev;
        prev = accepts;
        Valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!Valid || accepts != prev) begin
                Valid = ($urandom_range(0, 2) != 0);
                Data  = 8'($urandom);
            end
            prev = accepts;
            @(negedge Clock);
            obs = {Ready, Frame, Last, Q, ready_l, q_l, frame_l, last_l}; exp = expected();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, obs, exp); end
            advance();
        end
        Valid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Valid = 1'b0;
        Data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_reset_mid_word();
        test_valid_pulse_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
